// File: rtl/riscv_nn_alu_sched.sv
// ----------------------------------------------------------------------------
// riscv_nn_alu_sched
//
// Shares one riscv_nn_alu_basic instance between NUM_REQ requesters (for
// example the core EX stage and the NN accumulator / post-processing engine).
// A round-robin arbiter picks one request, its operation is latched and driven
// to the ALU for one cycle (longer if the ALU stalls), and the registered
// result/comparison is held in a valid/ready response to the owner. When the
// owner consumes the response, the next winner is granted in that same cycle,
// so the peak rate is one operation every two cycles.
//
// Parameters
//   NUM_REQ   number of requesters, 2..4
//   ALU_OP_W  operator field width, same as ALU_OP_WIDTH of the core defines
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_i / req_ready_o     per-requester request handshake
//   req_operator_i, req_op_a_i,
//   req_op_b_i, req_vec_mode_i    packed payloads, slice r = requester r
//   rsp_valid_o / rsp_ready_i     per-requester response handshake
//   rsp_result_o, rsp_cmp_o       shared response data for the rsp owner
//   alu_*_o                       operands/control to the shared ALU
//   alu_result_i, alu_cmp_i,
//   alu_ready_i                   results and ready from the shared ALU
//
// Build option
//   RISCV_NN_ALU_SCHED_PERF_EN    adds perf_ops_o (accepted requests) and
//                                 perf_conflict_o (cycles with a valid request
//                                 not accepted); both saturate, cleared by rst.
//
// States
//   state  | meaning
//   IDLE   | no operation in flight, any valid request is accepted
//   EXEC   | latched operation driven to the ALU, waiting for alu_ready_i
//   RESP   | result held for the owner until its rsp_ready_i
// ----------------------------------------------------------------------------
module riscv_nn_alu_sched #(
    parameter int NUM_REQ  = 2,
    parameter int ALU_OP_W = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*ALU_OP_W-1:0]  req_operator_i,
    input  logic [NUM_REQ*32-1:0]        req_op_a_i,
    input  logic [NUM_REQ*32-1:0]        req_op_b_i,
    input  logic [NUM_REQ*3-1:0]         req_vec_mode_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    input  logic [NUM_REQ-1:0]           rsp_ready_i,
    output logic [31:0]                  rsp_result_o,
    output logic                         rsp_cmp_o,
    output logic [ALU_OP_W-1:0]          alu_operator_o,
    output logic [31:0]                  alu_op_a_o,
    output logic [31:0]                  alu_op_b_o,
    output logic [31:0]                  alu_op_c_o,
    output logic [2:0]                   alu_vec_mode_o,
    output logic [4:0]                   alu_bmask_a_o,
    output logic [4:0]                   alu_bmask_b_o,
    output logic [1:0]                   alu_imm_vec_ext_o,
    output logic                         alu_ex_ready_o,
`ifdef RISCV_NN_ALU_SCHED_PERF_EN
    output logic [31:0]                  perf_ops_o,
    output logic [31:0]                  perf_conflict_o,
`endif
    input  logic [31:0]                  alu_result_i,
    input  logic                         alu_cmp_i,
    input  logic                         alu_ready_i
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [ALU_OP_W-1:0]  op_q;
    logic [31:0]          a_q;
    logic [31:0]          b_q;
    logic [2:0]           vm_q;
    logic [31:0]          result_q;
    logic                 cmp_q;

    logic [IDX_W-1:0]     win;
    logic                 found;
    logic                 owner_ack;
    logic                 grant;
    logic [ALU_OP_W-1:0]  sel_op;
    logic [31:0]          sel_a;
    logic [31:0]          sel_b;
    logic [2:0]           sel_vm;

    // Round-robin search starting one past the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!found && (r == (int'(rr_ptr) + i) % NUM_REQ) && req_valid_i[r]) begin
                    found = 1'b1;
                    win   = IDX_W'(r);
                end
            end
        end
    end

    // Payload of the winner and response-ready of the current owner.
    always_comb begin
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_vm    = '0;
        owner_ack = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (IDX_W'(r) == win) begin
                sel_op = req_operator_i[r*ALU_OP_W +: ALU_OP_W];
                sel_a  = req_op_a_i[r*32 +: 32];
                sel_b  = req_op_b_i[r*32 +: 32];
                sel_vm = req_vec_mode_i[r*3 +: 3];
            end
            if (IDX_W'(r) == owner) begin
                owner_ack = rsp_ready_i[r];
            end
        end
    end

    // A new grant is only possible when nothing is in flight, or when the
    // current response is being consumed this cycle. Reset suppresses it.
    assign grant = !rst && found &&
                   ((state == S_IDLE) || ((state == S_RESP) && owner_ack));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (grant) state_next = S_EXEC;
            S_EXEC: if (alu_ready_i) state_next = S_RESP;
            S_RESP: if (owner_ack) state_next = grant ? S_EXEC : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= IDX_W'(NUM_REQ - 1);
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            vm_q     <= '0;
            result_q <= '0;
            cmp_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                owner  <= win;
                rr_ptr <= win;
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                vm_q   <= sel_vm;
            end
            if ((state == S_EXEC) && alu_ready_i) begin
                result_q <= alu_result_i;
                cmp_q    <= alu_cmp_i;
            end
        end
    end

    assign req_ready_o       = grant ? (NUM_REQ'(1) << win) : '0;
    assign rsp_valid_o       = (state == S_RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign rsp_result_o      = result_q;
    assign rsp_cmp_o         = cmp_q;

    // ALU inputs stay on the latched operation outside EXEC to avoid toggling.
    assign alu_operator_o    = op_q;
    assign alu_op_a_o        = a_q;
    assign alu_op_b_o        = b_q;
    assign alu_vec_mode_o    = vm_q;
    assign alu_op_c_o        = '0;
    assign alu_bmask_a_o     = '0;
    assign alu_bmask_b_o     = '0;
    assign alu_imm_vec_ext_o = '0;
    assign alu_ex_ready_o    = (state == S_EXEC);

`ifdef RISCV_NN_ALU_SCHED_PERF_EN
    logic conflict;

    assign conflict = |(req_valid_i & ~req_ready_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_o      <= '0;
            perf_conflict_o <= '0;
        end else begin
            if (grant && (perf_ops_o != 32'hFFFF_FFFF)) begin
                perf_ops_o <= perf_ops_o + 32'd1;
            end
            if (conflict && (perf_conflict_o != 32'hFFFF_FFFF)) begin
                perf_conflict_o <= perf_conflict_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_nn_alu_sched.sv
module tb_riscv_nn_alu_sched;

    localparam int NUM_REQ  = 2;
    localparam int ALU_OP_W = 7;

    localparam logic [6:0] OP_ADD  = 7'b0011000;
    localparam logic [6:0] OP_SLTS = 7'b0000010;
    localparam logic [6:0] OP_GTU  = 7'b0001001;
    localparam logic [2:0] VEC8    = 3'b011;
    localparam logic [2:0] VEC32   = 3'b000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [6:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [2:0]  vm0 = '0, vm1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_result;
    logic        rsp_cmp;
    logic [6:0]  alu_operator;
    logic [31:0] alu_op_a, alu_op_b, alu_op_c;
    logic [2:0]  alu_vec_mode;
    logic [4:0]  alu_bmask_a, alu_bmask_b;
    logic [1:0]  alu_imm_vec_ext;
    logic        alu_ex_ready;
    logic [31:0] alu_result;
    logic        alu_cmp;
    logic        alu_stall = 1'b0;
`ifdef RISCV_NN_ALU_SCHED_PERF_EN
    logic [31:0] perf_ops, perf_conflict;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_rdy [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [1:0] exp_vld [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    always #5 clk = ~clk;

    riscv_nn_alu_sched #(.NUM_REQ(NUM_REQ), .ALU_OP_W(ALU_OP_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_operator_i    ({op1, op0}),
        .req_op_a_i        ({a1, a0}),
        .req_op_b_i        ({b1, b0}),
        .req_vec_mode_i    ({vm1, vm0}),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_result_o      (rsp_result),
        .rsp_cmp_o         (rsp_cmp),
        .alu_operator_o    (alu_operator),
        .alu_op_a_o        (alu_op_a),
        .alu_op_b_o        (alu_op_b),
        .alu_op_c_o        (alu_op_c),
        .alu_vec_mode_o    (alu_vec_mode),
        .alu_bmask_a_o     (alu_bmask_a),
        .alu_bmask_b_o     (alu_bmask_b),
        .alu_imm_vec_ext_o (alu_imm_vec_ext),
        .alu_ex_ready_o    (alu_ex_ready),
`ifdef RISCV_NN_ALU_SCHED_PERF_EN
        .perf_ops_o        (perf_ops),
        .perf_conflict_o   (perf_conflict),
`endif
        .alu_result_i      (alu_result),
        .alu_cmp_i         (alu_cmp),
        .alu_ready_i       (!alu_stall)
    );

    // Small behavioural stand-in for the shared ALU.
    always_comb begin
        alu_result = '0;
        alu_cmp    = 1'b0;
        case (alu_operator)
            OP_ADD: alu_result = alu_op_a + alu_op_b;
            OP_SLTS: begin
                alu_cmp    = $signed(alu_op_a) < $signed(alu_op_b);
                alu_result = {31'b0, alu_cmp};
            end
            OP_GTU: begin
                if (alu_vec_mode == VEC8) begin
                    for (int k = 0; k < 4; k++) begin
                        alu_result[8*k +: 8] = (alu_op_a[8*k +: 8] > alu_op_b[8*k +: 8]) ? 8'hFF : 8'h00;
                    end
                    alu_cmp = (alu_result != 32'd0);
                end else begin
                    alu_cmp    = alu_op_a > alu_op_b;
                    alu_result = {31'b0, alu_cmp};
                end
            end
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_ex_ready", 32'(alu_ex_ready), 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_alu_a", alu_op_a, 32'h0);
        chk("rst_alu_c", alu_op_c, 32'h0);

        // Single ADD on req0: accept at T, response at T+2
        cyc(); req_valid = 2'b01; op0 = OP_ADD; a0 = 32'd5; b0 = 32'd7; vm0 = VEC32;
        #1; chk("add_req_ready_T", 32'(req_ready), 32'h1);
        cyc(); req_valid = 2'b00;
        #1; chk("add_ex_ready_T1", 32'(alu_ex_ready), 32'h1);
        chk("add_alu_a_T1", alu_op_a, 32'd5);
        chk("add_no_ready_exec", 32'(req_ready), 32'h0);
        chk("add_rsp_valid_T1", 32'(rsp_valid), 32'h0);
        cyc();
        #1; chk("add_rsp_valid_T2", 32'(rsp_valid), 32'h1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_ex_ready_T2", 32'(alu_ex_ready), 32'h0);
        rsp_ready = 2'b01;
        cyc();
        #1; chk("add_rsp_gone", 32'(rsp_valid), 32'h0);

        // Two contending requesters, back-to-back grants 0,1,0,1
        do_reset();
        for (int c = 0; c < 7; c++) begin
            cyc();
            if (c == 0) begin
                req_valid = 2'b11; rsp_ready = 2'b11;
                op0 = OP_ADD; a0 = 32'd1;  b0 = 32'd2;
                op1 = OP_ADD; a1 = 32'd10; b1 = 32'd20; vm1 = VEC32;
            end
            #1;
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
            chk($sformatf("rr_valid_c%0d", c), 32'(rsp_valid), 32'(exp_vld[c]));
            if (exp_vld[c] == 2'b01) chk($sformatf("rr_res0_c%0d", c), rsp_result, 32'd3);
            if (exp_vld[c] == 2'b10) chk($sformatf("rr_res1_c%0d", c), rsp_result, 32'd30);
        end
        cyc(); req_valid = 2'b00;
        #1; chk("rr_drain_exec", 32'(alu_ex_ready), 32'h1);
        cyc();
        #1; chk("rr_drain_valid", 32'(rsp_valid), 32'h2);
        chk("rr_drain_result", rsp_result, 32'd30);
        cyc();
        #1; chk("rr_drain_idle", 32'(rsp_valid), 32'h0);

        // req1 SLTS held in RESP while owner withholds rsp_ready
        cyc(); rsp_ready = 2'b00; req_valid = 2'b10;
        op1 = OP_SLTS; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
        #1; chk("slts_accept", 32'(req_ready), 32'h2);
        cyc(); req_valid = 2'b01; op0 = OP_ADD; a0 = 32'd2; b0 = 32'd3; vm0 = VEC32;
        #1; chk("slts_exec_no_ready", 32'(req_ready), 32'h0);
        chk("slts_alu_a", alu_op_a, 32'hFFFF_FFFF);
        for (int k = 0; k < 5; k++) begin
            cyc(); rsp_ready = 2'b01;   // non-owner ready must be ignored
            #1;
            chk($sformatf("slts_hold_valid_%0d", k), 32'(rsp_valid), 32'h2);
            chk($sformatf("slts_hold_res_%0d", k), rsp_result, 32'd1);
            chk($sformatf("slts_hold_cmp_%0d", k), 32'(rsp_cmp), 32'h1);
            chk($sformatf("slts_hold_noready_%0d", k), 32'(req_ready), 32'h0);
        end
        cyc(); rsp_ready = 2'b10;
        #1; chk("slts_hs_grant0", 32'(req_ready), 32'h1);
        chk("slts_hs_valid", 32'(rsp_valid), 32'h2);
        cyc(); rsp_ready = 2'b00; req_valid = 2'b00; alu_stall = 1'b1;
        #1; chk("stall_exec0", 32'(alu_ex_ready), 32'h1);
        chk("stall_alu_a", alu_op_a, 32'd2);
        cyc();
        #1; chk("stall_exec1", 32'(alu_ex_ready), 32'h1);
        chk("stall_no_rsp", 32'(rsp_valid), 32'h0);
        alu_stall = 1'b0;
        cyc();
        #1; chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("stall_result", rsp_result, 32'd5);
        chk("stall_cmp", 32'(rsp_cmp), 32'h0);
        rsp_ready = 2'b01;
        cyc();
        #1; chk("stall_rsp_gone", 32'(rsp_valid), 32'h0);

        // Vector byte GTU
        cyc(); req_valid = 2'b01; op0 = OP_GTU; a0 = 32'h8001_7F00; b0 = 32'h7F02_FF00; vm0 = VEC8;
        #1; chk("gtu_accept", 32'(req_ready), 32'h1);
        cyc(); req_valid = 2'b00;
        #1; chk("gtu_vec_mode", 32'(alu_vec_mode), 32'(VEC8));
        cyc();
        #1; chk("gtu_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("gtu_result", rsp_result, 32'hFF00_0000);
        cyc();
        #1; chk("gtu_rsp_gone", 32'(rsp_valid), 32'h0);

        // Reset while in EXEC
        cyc(); req_valid = 2'b01; op0 = OP_ADD; a0 = 32'd9; b0 = 32'd9; vm0 = VEC32;
        #1; chk("rstx_accept", 32'(req_ready), 32'h1);
        cyc(); req_valid = 2'b00; rst = 1'b1;
        #1; chk("rstx_in_exec", 32'(alu_ex_ready), 32'h1);
        cyc(); rst = 1'b0;
        #1; chk("rstx_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstx_ex_ready", 32'(alu_ex_ready), 32'h0);
        chk("rstx_alu_a", alu_op_a, 32'h0);
        chk("rstx_alu_op", 32'(alu_operator), 32'h0);
        chk("rstx_result", rsp_result, 32'h0);
        chk("rstx_req_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b11;
        #1; chk("rstx_req0_first", 32'(req_ready), 32'h1);
        cyc(); req_valid = 2'b00; rsp_ready = 2'b11;
        cyc();
        #1; chk("rstx_rsp_valid2", 32'(rsp_valid), 32'h1);
        chk("rstx_result2", rsp_result, 32'd18);
        cyc();
        #1; chk("rstx_rsp_gone", 32'(rsp_valid), 32'h0);

`ifdef RISCV_NN_ALU_SCHED_PERF_EN
        // Three back-to-back ops from two requesters: five waiting cycles
        do_reset();
        cyc(); req_valid = 2'b11; rsp_ready = 2'b11;
        op0 = OP_ADD; op1 = OP_ADD;
        cyc(); cyc(); cyc(); cyc();
        cyc(); req_valid = 2'b00;
        cyc(); cyc();
        #1; chk("perf_ops", perf_ops, 32'd3);
        chk("perf_conflict", perf_conflict, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
